// File: rtl/msx_mem_arbiter.sv
// msx_mem_arbiter
//  Shares one single-port memory between the Z80 bus and the ioctl download
//  writer. Download bytes go into a small FIFO and are written to memory in
//  cycles the CPU is not using. CPU accesses have priority and are stalled
//  through WAIT_n until they have been served.
//
//  Ports
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/d_i  CPU access request (level), direction, address, data
//   cpu_q_o                    CPU read data, held until the next read completes
//   cpu_wait_n_o               0 = stall the CPU
//   dl_wr_i/addr_i/d_i         download byte strobe, address, data
//   dl_full_o, dl_ovf_o        FIFO full; sticky "byte dropped" flag
//   mem_addr_o/d_o/we_o        memory address, write data, write enable
//   mem_q_i                    memory read data, valid MEM_LAT cycles after mem_addr_o
module msx_mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int FIFO_AW = 2,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_d_i,
  output logic [7:0]        cpu_q_o,
  output logic              cpu_wait_n_o,
  input  logic              dl_wr_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_d_i,
  output logic              dl_full_o,
  output logic              dl_ovf_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_d_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_q_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] DEPTH_P = (FIFO_AW + 1)'(DEPTH);
  localparam logic [1:0]       LAT_LAST = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_CPU_WR, S_DL_WR} state_t;

  state_t              state_q, state_d;
  logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                cpu_done_q, cpu_done_d;
  logic [7:0]          cpu_q_q, cpu_q_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_d_q, mem_d_d;
  logic                mem_we_q, mem_we_d;
  logic [1:0]          lat_q, lat_d;

  logic [ADDR_W-1:0]   fifo_addr_mem [DEPTH];
  logic [7:0]          fifo_data_mem [DEPTH];

  logic                cpu_pending;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [FIFO_AW-1:0]  head_idx;

  assign cpu_pending = cpu_req_i & ~cpu_done_q;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign head_idx    = rd_ptr_q[FIFO_AW-1:0];

  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    cpu_q_d    = cpu_q_q;
    // done flag survives only while the request is held; dropping req re-arms it
    cpu_done_d = cpu_done_q & cpu_req_i;
    lat_d      = lat_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a full FIFO gets one slot freed even against a waiting CPU so the
        // downloader can never be blocked behind an endless stream of accesses
        if ((full_q && cpu_pending) || (!cpu_pending && !fifo_empty)) begin
          state_d    = S_DL_WR;
          mem_we_d   = 1'b1;
          mem_addr_d = fifo_addr_mem[head_idx];
          mem_d_d    = fifo_data_mem[head_idx];
          pop        = 1'b1;
        end else if (cpu_pending) begin
          mem_addr_d = cpu_addr_i;
          if (cpu_we_i) begin
            state_d    = S_CPU_WR;
            mem_we_d   = 1'b1;
            mem_d_d    = cpu_d_i;
            cpu_done_d = 1'b1;
          end else begin
            state_d = S_CPU_RD;
            lat_d   = 2'd0;
          end
        end
      end
      S_CPU_RD: begin
        if (lat_q == LAT_LAST) begin
          cpu_q_d    = mem_q_i;
          cpu_done_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_CPU_WR: state_d = S_IDLE;
      S_DL_WR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // a pop in the same cycle frees the head slot, so a strobe is accepted then
  always_comb begin
    push     = dl_wr_i & (~full_q | pop);
    ovf_d    = ovf_q | (dl_wr_i & full_q & ~pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    full_d   = ((wr_ptr_d - rd_ptr_d) == DEPTH_P);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cpu_done_q <= 1'b0;
      cpu_q_q    <= 8'hFF;
      mem_addr_q <= '0;
      mem_d_q    <= 8'h00;
      mem_we_q   <= 1'b0;
      lat_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      cpu_done_q <= cpu_done_d;
      cpu_q_q    <= cpu_q_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_we_q   <= mem_we_d;
      lat_q      <= lat_d;
    end
  end

  // storage needs no reset: the pointers decide what is valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_q[FIFO_AW-1:0]] <= dl_addr_i;
      fifo_data_mem[wr_ptr_q[FIFO_AW-1:0]] <= dl_d_i;
    end
  end

  // WAIT_n is released while the arbiter is held in reset
  assign cpu_wait_n_o = ~(cpu_req_i & ~cpu_done_q & reset_n_i);
  assign cpu_q_o      = cpu_q_q;
  assign dl_full_o    = full_q;
  assign dl_ovf_o     = ovf_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_d_o      = mem_d_q;
  assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_msx_mem_arbiter.sv
module tb_msx_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [7:0]  cpu_d = '0;
  logic [7:0]  cpu_q;
  logic        cpu_wait_n;
  logic        dl_wr = 1'b0;
  logic [17:0] dl_addr = '0;
  logic [7:0]  dl_d = '0;
  logic        dl_full;
  logic        dl_ovf;
  logic [17:0] mem_addr;
  logic [7:0]  mem_d;
  logic        mem_we;
  logic [7:0]  mem_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msx_mem_arbiter #(.ADDR_W(18), .FIFO_AW(2), .MEM_LAT(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_d_i(cpu_d),
    .cpu_q_o(cpu_q), .cpu_wait_n_o(cpu_wait_n),
    .dl_wr_i(dl_wr), .dl_addr_i(dl_addr), .dl_d_i(dl_d),
    .dl_full_o(dl_full), .dl_ovf_o(dl_ovf),
    .mem_addr_o(mem_addr), .mem_d_o(mem_d), .mem_we_o(mem_we), .mem_q_i(mem_q)
  );

  // memory model: combinational read (data ready by the next edge), write on edge,
  // plus a log of every write the arbiter issues
  logic [7:0]  mem [0:(1<<18)-1];
  logic        pl_en = 1'b0;
  logic [17:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [17:0] log_a [0:63];
  logic [7:0]  log_d [0:63];
  int          log_n = 0;

  assign mem_q = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_d;
      if (log_n < 64) begin
        log_a[log_n] <= mem_addr;
        log_d[log_n] <= mem_d;
      end
      log_n <= log_n + 1;
    end
  end

  typedef struct {
    logic        req;
    logic        cwe;
    logic [17:0] caddr;
    logic [7:0]  cd;
    logic        dl;
    logic [17:0] daddr;
    logic [7:0]  dd;
    logic        e_wait;
    logic        e_we;
    logic [17:0] e_addr;
    logic [7:0]  e_d;
    logic        e_full;
    logic        e_ovf;
    logic [7:0]  e_q;
    logic        chk_addr;
  } vec_t;

  vec_t tbl [0:22];

  function automatic vec_t mk(logic req, logic cwe, logic [17:0] caddr, logic [7:0] cd,
                              logic dl, logic [17:0] daddr, logic [7:0] dd,
                              logic e_wait, logic e_we, logic [17:0] e_addr, logic [7:0] e_d,
                              logic e_full, logic e_ovf, logic [7:0] e_q, logic chk_addr);
    vec_t v;
    v.req = req; v.cwe = cwe; v.caddr = caddr; v.cd = cd;
    v.dl = dl; v.daddr = daddr; v.dd = dd;
    v.e_wait = e_wait; v.e_we = e_we; v.e_addr = e_addr; v.e_d = e_d;
    v.e_full = e_full; v.e_ovf = e_ovf; v.e_q = e_q; v.chk_addr = chk_addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  initial begin
    int base;

    // test 4: CPU write 0x100=A5 arrives with two download bytes queued
    tbl[0]  = mk(0,0,18'h0,8'h0,     1,18'h200,8'h01, 1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[1]  = mk(1,1,18'h100,8'hA5,  1,18'h201,8'h02, 0,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[2]  = mk(1,1,18'h100,8'hA5,  0,18'h0,8'h0,    1,1,18'h100,8'hA5,  0,0,8'h5A,0);
    tbl[3]  = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[4]  = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,1,18'h200,8'h01,  0,0,8'h5A,0);
    tbl[5]  = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[6]  = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,1,18'h201,8'h02,  0,0,8'h5A,0);
    tbl[7]  = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,0,18'h0,8'h0,     0,0,8'h5A,0);
    // test 5: strobe stream fills the FIFO, CPU read waits behind a full FIFO
    tbl[8]  = mk(0,0,18'h0,8'h0,     1,18'h400,8'hA0, 1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[9]  = mk(0,0,18'h0,8'h0,     1,18'h401,8'hA1, 1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[10] = mk(0,0,18'h0,8'h0,     1,18'h402,8'hA2, 1,1,18'h400,8'hA0,  0,0,8'h5A,0);
    tbl[11] = mk(0,0,18'h0,8'h0,     1,18'h403,8'hA3, 1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[12] = mk(0,0,18'h0,8'h0,     1,18'h404,8'hA4, 1,1,18'h401,8'hA1,  0,0,8'h5A,0);
    tbl[13] = mk(0,0,18'h0,8'h0,     1,18'h405,8'hA5, 1,0,18'h0,8'h0,     0,0,8'h5A,0);
    tbl[14] = mk(0,0,18'h0,8'h0,     1,18'h406,8'hA6, 1,1,18'h402,8'hA2,  0,0,8'h5A,0);
    tbl[15] = mk(1,0,18'h300,8'h0,   1,18'h407,8'hA7, 0,0,18'h0,8'h0,     1,0,8'h5A,0);
    tbl[16] = mk(1,0,18'h300,8'h0,   1,18'h408,8'hA8, 0,1,18'h403,8'hA3,  1,0,8'h5A,0);
    tbl[17] = mk(1,0,18'h300,8'h0,   0,18'h0,8'h0,    0,0,18'h0,8'h0,     1,1,8'h5A,0);
    tbl[18] = mk(1,0,18'h300,8'h0,   0,18'h0,8'h0,    0,1,18'h404,8'hA4,  0,1,8'h5A,0);
    tbl[19] = mk(1,0,18'h300,8'h0,   0,18'h0,8'h0,    0,0,18'h0,8'h0,     0,1,8'h5A,0);
    tbl[20] = mk(1,0,18'h300,8'h0,   0,18'h0,8'h0,    0,0,18'h300,8'h0,   0,1,8'h5A,1);
    tbl[21] = mk(1,0,18'h300,8'h0,   0,18'h0,8'h0,    1,0,18'h0,8'h0,     0,1,8'h77,0);
    tbl[22] = mk(0,0,18'h0,8'h0,     0,18'h0,8'h0,    1,1,18'h405,8'hA5,  0,1,8'h77,0);

    // reset held while the memory model is preloaded
    preload(18'h1234, 8'h5A);
    preload(18'h0300, 8'h77);
    preload(18'h0408, 8'h00);
    preload(18'h0500, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // test 1: idle after reset
    tick();
    @(negedge clk);
    chk("rst wait_n", cpu_wait_n, 1);
    chk("rst cpu_q", cpu_q, 8'hFF);
    chk("rst mem_we", mem_we, 0);
    chk("rst full", dl_full, 0);
    chk("rst ovf", dl_ovf, 0);
    chk("rst mem_addr", mem_addr, 0);

    // test 2: CPU read of 0x1234, wait_n low for exactly 2 clocks
    base = log_n;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h1234;
    @(negedge clk);
    chk("rd c0 wait_n", cpu_wait_n, 0);
    tick();
    @(negedge clk);
    chk("rd c1 wait_n", cpu_wait_n, 0);
    chk("rd c1 mem_addr", mem_addr, 18'h1234);
    tick();
    @(negedge clk);
    chk("rd c2 wait_n", cpu_wait_n, 1);
    chk("rd c2 cpu_q", cpu_q, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rd hold%0d wait_n", i), cpu_wait_n, 1);
      chk($sformatf("rd hold%0d mem_we", i), mem_we, 0);
    end
    chk("rd no writes", log_n - base, 0);
    tick();
    cpu_req = 1'b0;

    // test 3: four download bytes with no CPU traffic
    tick();
    base = log_n;
    for (int i = 0; i < 4; i++) begin
      dl_wr = 1'b1; dl_addr = 18'(i); dl_d = 8'(8'h11 * (i + 1));
      tick();
    end
    dl_wr = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("dl write count", log_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dl log%0d addr", i), log_a[base + i], i);
      chk($sformatf("dl log%0d data", i), log_d[base + i], 8'h11 * (i + 1));
      chk($sformatf("dl mem[%0d]", i), mem[i], 8'h11 * (i + 1));
    end
    chk("dl full after", dl_full, 0);

    // tests 4 and 5: cycle-by-cycle vectors
    for (int k = 0; k < 23; k++) begin
      @(posedge clk);
      #1;
      cpu_req = tbl[k].req; cpu_we = tbl[k].cwe; cpu_addr = tbl[k].caddr; cpu_d = tbl[k].cd;
      dl_wr = tbl[k].dl; dl_addr = tbl[k].daddr; dl_d = tbl[k].dd;
      @(negedge clk);
      chk($sformatf("v%0d wait_n", k), cpu_wait_n, tbl[k].e_wait);
      chk($sformatf("v%0d mem_we", k), mem_we, tbl[k].e_we);
      if (tbl[k].e_we || tbl[k].chk_addr)
        chk($sformatf("v%0d mem_addr", k), mem_addr, tbl[k].e_addr);
      if (tbl[k].e_we)
        chk($sformatf("v%0d mem_d", k), mem_d, tbl[k].e_d);
      chk($sformatf("v%0d full", k), dl_full, tbl[k].e_full);
      chk($sformatf("v%0d ovf", k), dl_ovf, tbl[k].e_ovf);
      chk($sformatf("v%0d cpu_q", k), cpu_q, tbl[k].e_q);
    end
    tick();
    dl_wr = 1'b0; cpu_req = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("wr mem[100]", mem[18'h100], 8'hA5);
    chk("dl mem[200]", mem[18'h200], 8'h01);
    chk("dl mem[201]", mem[18'h201], 8'h02);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf mem[40%0d]", i), mem[18'h400 + 18'(i)], 8'hA0 + 8'(i));
    chk("dropped mem[408]", mem[18'h408], 8'h00);
    chk("ovf sticky", dl_ovf, 1);

    // test 6: reset in the middle of a CPU read with one byte queued
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h1234;
    dl_wr = 1'b1; dl_addr = 18'h500; dl_d = 8'hB0;
    tick();
    dl_wr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst wait_n", cpu_wait_n, 1);
    chk("arst cpu_q", cpu_q, 8'hFF);
    chk("arst mem_we", mem_we, 0);
    chk("arst mem_addr", mem_addr, 0);
    chk("arst mem_d", mem_d, 0);
    chk("arst full", dl_full, 0);
    chk("arst ovf", dl_ovf, 0);
    cpu_req = 1'b0;
    base = log_n;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("post-rst%0d mem_we", i), mem_we, 0);
    end
    chk("post-rst no writes", log_n - base, 0);
    chk("post-rst mem[500]", mem[18'h500], 8'h00);
    chk("post-rst cpu_q", cpu_q, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
